// File: rtl/ss_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ss_pkg
// Brief   : Shared types and constants for the game timer run-control block.
// Revision: 1.0
// ============================================================================
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } ss_state_t;

    localparam int unsigned C_TICK_DIV_DEFAULT = 10_000_000;
    localparam int unsigned C_DIGIT_W          = 4;
    localparam int unsigned C_NUM_DIGITS       = 4;
    localparam int unsigned C_COUNT_W          = C_DIGIT_W * C_NUM_DIGITS;

endpackage
`default_nettype wire

// File: rtl/ss_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : ss_edge_det
// Brief   : Rising-edge detector; history resets high so a held level is not
//           mistaken for a press.
// Revision: 1.0
// ============================================================================
module ss_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic r_hist;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= din;
        end
    end

    assign rise = din & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/ss_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ss_timer_ctrl
// Brief   : Run-control sequencer for the four-digit BCD game timer.
// Revision: 1.0
// ============================================================================
module ss_timer_ctrl
    import ss_pkg::*;
#(
    parameter int unsigned TICK_DIV = C_TICK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_start,
    input  logic                 btn_pause,
    input  logic                 game_over_in,
    input  logic [C_COUNT_W-1:0] time_limit,
    input  logic [C_COUNT_W-1:0] count,
    output logic                 cnt_en,
    output logic                 cnt_clr,
    output logic                 running,
    output logic                 paused,
    output logic                 time_up,
    output logic [1:0]           state
);

    localparam int unsigned          C_DIV_W    = $clog2(TICK_DIV);
    localparam logic [C_DIV_W-1:0]   C_DIV_LAST = C_DIV_W'(TICK_DIV - 1);

    ss_state_t          r_state;
    logic [C_DIV_W-1:0] r_div;
    logic               r_cnt_en;
    logic               r_time_up;

    logic               w_start_edge;
    logic               w_pause_edge;
    logic               w_wrap;
    logic               w_limit_hit;
    logic [C_DIV_W-1:0] w_div_next;

    ss_edge_det u_start_det (
        .clk   (clk),
        .reset (reset),
        .din   (btn_start),
        .rise  (w_start_edge)
    );

    ss_edge_det u_pause_det (
        .clk   (clk),
        .reset (reset),
        .din   (btn_pause),
        .rise  (w_pause_edge)
    );

    assign w_wrap      = (r_div == C_DIV_LAST);
    assign w_div_next  = w_wrap ? '0 : r_div + 1'b1;
    // A zero limit disables the timeout; non-BCD limits simply never match.
    assign w_limit_hit = (time_limit != '0) && (count == time_limit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_cnt_en  <= 1'b0;
            r_time_up <= 1'b0;
        end else begin
            r_cnt_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_div     <= '0;
                    r_time_up <= 1'b0;
                    if (w_start_edge) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Leaving RUN freezes the prescaler so the tick phase survives a pause.
                    if (game_over_in) begin
                        r_state   <= OVER;
                        r_time_up <= 1'b0;
                        if (w_wrap) begin
                            r_div <= '0;
                        end
                    end else if (w_limit_hit) begin
                        r_state   <= OVER;
                        r_time_up <= 1'b1;
                        if (w_wrap) begin
                            r_div <= '0;
                        end
                    end else if (w_pause_edge) begin
                        r_state <= PAUSE;
                    end else begin
                        r_div    <= w_div_next;
                        r_cnt_en <= w_wrap;
                    end
                end
                PAUSE: begin
                    if (w_start_edge || w_pause_edge) begin
                        r_state <= RUN;
                    end
                end
                OVER: begin
                    if (w_start_edge) begin
                        r_state   <= IDLE;
                        r_time_up <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cnt_en  = r_cnt_en;
    assign time_up = r_time_up;
    assign state   = r_state;
    assign cnt_clr = (r_state == IDLE);
    assign running = (r_state == RUN);
    assign paused  = (r_state == PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_ss_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ss_timer_ctrl
// Brief   : Self-checking bench for ss_timer_ctrl with a BCD counter model.
// Revision: 1.0
// ============================================================================
module tb_ss_timer_ctrl;
    import ss_pkg::*;

    localparam int unsigned C_TD = 4;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        btn_start    = 1'b1;
    logic        btn_pause    = 1'b0;
    logic        game_over_in = 1'b0;
    logic [15:0] time_limit   = 16'h0000;
    logic [15:0] count;
    logic        cnt_en;
    logic        cnt_clr;
    logic        running;
    logic        paused;
    logic        time_up;
    logic [1:0]  state;

    logic [15:0] r_model_cnt = 16'h0000;
    int          n_chk   = 0;
    int          n_err   = 0;
    int          n_pulse = 0;
    int          p0;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ss_timer_ctrl #(.TICK_DIV(C_TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start    (btn_start),
        .btn_pause    (btn_pause),
        .game_over_in (game_over_in),
        .time_limit   (time_limit),
        .count        (count),
        .cnt_en       (cnt_en),
        .cnt_clr      (cnt_clr),
        .running      (running),
        .paused       (paused),
        .time_up      (time_up),
        .state        (state)
    );

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int d = 0; d < 4; d++) begin
            if (r[d*4 +: 4] == 4'd9) begin
                r[d*4 +: 4] = 4'd0;
            end else begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                break;
            end
        end
        return r;
    endfunction

    // Downstream BCD counter chain
    always @(posedge clk) begin
        if (cnt_clr) begin
            r_model_cnt <= 16'h0000;
        end else if (cnt_en) begin
            r_model_cnt <= bcd_inc(r_model_cnt);
        end
        if (cnt_en) begin
            n_pulse <= n_pulse + 1;
        end
    end
    assign count = r_model_cnt;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] mk(input logic [1:0] st, input logic en, input logic tu);
        return {st, en, st == 2'b00, st == 2'b01, st == 2'b10, tu};
    endfunction

    // One clock per call; the expected outputs after this edge are queued.
    task automatic step(input string tag, input logic [1:0] st, input logic en, input logic tu);
        exp_t e;
        e.tag = tag;
        e.v   = mk(st, en, tu);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, {9'd0, state, cnt_en, cnt_clr, running, paused, time_up}, {9'd0, e.v});
        end
    end

    initial begin
        // Reset with start held, then release and press
        for (int i = 0; i < 3; i++) step("rst", IDLE, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("held_start", IDLE, 1'b0, 1'b0);
        btn_start = 1'b0;
        step("released", IDLE, 1'b0, 1'b0);
        btn_start = 1'b1;
        step("start", RUN, 1'b0, 1'b0);
        btn_start = 1'b0;
        for (int k = 1; k <= 8; k++) step($sformatf("run_a%0d", k), RUN, (k % C_TD) == 0, 1'b0);
        chk("cnt_after_2_ticks", r_model_cnt, 16'h0001);

        // Pause at div==2, resume with start
        step("run_a9", RUN, 1'b0, 1'b0);
        step("run_a10", RUN, 1'b0, 1'b0);
        btn_pause = 1'b1;
        step("pause", PAUSE, 1'b0, 1'b0);
        btn_pause = 1'b0;
        for (int k = 0; k < 20; k++) step($sformatf("paused%0d", k), PAUSE, 1'b0, 1'b0);
        chk("cnt_paused", r_model_cnt, 16'h0002);
        btn_start = 1'b1;
        step("resume", RUN, 1'b0, 1'b0);
        btn_start = 1'b0;
        step("resume1", RUN, 1'b0, 1'b0);
        step("resume_tick", RUN, 1'b1, 1'b0);

        // game_over_in on the wrap cycle
        for (int k = 3; k <= 5; k++) step($sformatf("run_b%0d", k), RUN, 1'b0, 1'b0);
        game_over_in = 1'b1;
        step("gameover", OVER, 1'b0, 1'b0);
        game_over_in = 1'b0;
        chk("cnt_gameover", r_model_cnt, 16'h0003);
        btn_pause = 1'b1;
        step("over_pause_ign", OVER, 1'b0, 1'b0);
        btn_pause = 1'b0;
        step("over_hold", OVER, 1'b0, 1'b0);
        chk("cnt_frozen", r_model_cnt, 16'h0003);
        btn_start = 1'b1;
        step("over_to_idle", IDLE, 1'b0, 1'b0);
        step("idle_held", IDLE, 1'b0, 1'b0);
        chk("cnt_cleared", r_model_cnt, 16'h0000);
        btn_start = 1'b0;
        step("idle_rel", IDLE, 1'b0, 1'b0);

        // Limit 0003, with a simultaneous pause edge on the match cycle
        time_limit = 16'h0003;
        p0 = n_pulse;
        btn_start = 1'b1;
        step("start_lim", RUN, 1'b0, 1'b0);
        btn_start = 1'b0;
        for (int k = 1; k <= 13; k++) step($sformatf("run_c%0d", k), RUN, (k % C_TD) == 0, 1'b0);
        btn_pause = 1'b1;
        step("limit_over", OVER, 1'b0, 1'b1);
        btn_pause = 1'b0;
        step("limit_hold1", OVER, 1'b0, 1'b1);
        step("limit_hold2", OVER, 1'b0, 1'b1);
        chk("limit_pulses", 16'(n_pulse - p0), 16'd3);
        chk("limit_cnt", r_model_cnt, 16'h0003);
        btn_start = 1'b1;
        step("limit_to_idle", IDLE, 1'b0, 1'b0);
        btn_start = 1'b0;
        step("idle2", IDLE, 1'b0, 1'b0);

        // Non-BCD limit never matches
        time_limit = 16'h00A0;
        btn_start = 1'b1;
        step("start_nb", RUN, 1'b0, 1'b0);
        btn_start = 1'b0;
        for (int k = 1; k <= 411; k++) step($sformatf("run_d%0d", k), RUN, (k % C_TD) == 0, 1'b0);
        chk("cnt_past_99", r_model_cnt, 16'h0102);

        // Reset mid-RUN at div==3, then a full first tick
        reset = 1'b0;
        step("rst_mid", IDLE, 1'b0, 1'b0);
        reset = 1'b1;
        step("rst_rel", IDLE, 1'b0, 1'b0);
        btn_start = 1'b1;
        step("restart", RUN, 1'b0, 1'b0);
        btn_start = 1'b0;
        chk("cnt_after_rst", r_model_cnt, 16'h0000);
        for (int k = 1; k <= 4; k++) step($sformatf("run_e%0d", k), RUN, k == 4, 1'b0);

        @(negedge clk);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
